// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared constants, types and small helpers for the 8x8 switch fabric front
// end. The package has no ports. It is imported by rr_grant_arb_if,
// rr_pick and rr_grant_arb.
// -----------------------------------------------------------------------------
package router_pkg;

    localparam int NUM_PORTS        = 8;
    localparam int ADDR_W           = 4;
    localparam int ADDR_INVALID_BIT = 3;

    typedef logic [2:0]           port_idx_t;
    typedef logic [NUM_PORTS-1:0] port_vec_t;
    typedef logic [ADDR_W-1:0]    addr_t;

    // One-hot vector with bit idx set.
    function automatic port_vec_t idx_to_onehot(input port_idx_t idx);
        return port_vec_t'(8'h01 << idx);
    endfunction

    // Output port selected by a head address.
    function automatic port_idx_t addr_dst(input addr_t a);
        return a[2:0];
    endfunction

    // Head address names no real output port.
    function automatic logic addr_invalid(input addr_t a);
        return a[ADDR_INVALID_BIT];
    endfunction

endpackage

// File: rtl/rr_grant_arb_if.sv
// -----------------------------------------------------------------------------
// rr_grant_arb_if
// Bundle between the FIFO/fabric side and the arbiter.
//   req[7:0]        input FIFO i non-empty
//   addr[7:0][3:0]  destination of the head word of input FIFO i
//   out_full[7:0]   output FIFO j full (exact flag)
//   grant[7:0]      one-hot or zero grant to the fabric
//   pop[7:0]        pop strobe to the input FIFOs (same as grant)
//   drop            current grant discards an invalid-destination word
// Modport master is the arbiter side. Modport slave is the FIFO/fabric side.
// -----------------------------------------------------------------------------
interface rr_grant_arb_if;
    import router_pkg::*;

    port_vec_t                              req;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]       addr;
    port_vec_t                              out_full;
    port_vec_t                              grant;
    port_vec_t                              pop;
    logic                                   drop;

    modport master (input req, addr, out_full, output grant, pop, drop);
    modport slave  (output req, addr, out_full, input grant, pop, drop);

endinterface

// File: rtl/rr_grant_arb_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating priority encoder.
//   elig[7:0]  candidate mask
//   ptr[2:0]   index with highest priority; the search wraps 7 -> 0
//   found      at least one candidate is set
//   idx[2:0]   first set candidate at or after ptr (0 when found = 0)
// -----------------------------------------------------------------------------
module rr_pick
    import router_pkg::*;
(
    input  port_vec_t elig,
    input  port_idx_t ptr,
    output logic      found,
    output port_idx_t idx
);

    // Walk from ptr outwards. The first hit sets found, and found masks every later candidate.
    always_comb begin
        port_idx_t cand_s;
        logic      hit_s;
        cand_s = 3'd0;
        hit_s  = 1'b0;
        found  = 1'b0;
        idx    = 3'd0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand_s = ptr + 3'(k);
            hit_s  = elig[cand_s] & ~found;
            found  = found | hit_s;
            idx    = hit_s ? cand_s : idx;
        end
    end

endmodule

// File: rtl/rr_grant_arb.sv
// -----------------------------------------------------------------------------
// rr_grant_arb
// Round-robin arbiter in front of the 8x8 switch fabric. It grants at most one
// input per cycle and pops that input FIFO in the same cycle.
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   rr_grant_arb_if.master (req, addr, out_full -> grant, pop, drop)
// Optional feature: define RR_ARB_DROP_EN to grant and discard heads whose
// destination is invalid (addr[3] = 1). Without the macro, such heads stall
// their input and drop is tied to 0.
// -----------------------------------------------------------------------------
module rr_grant_arb
    import router_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    rr_grant_arb_if.master  bus
);

    port_vec_t grant_r;
    port_idx_t ptr_r;
    port_idx_t gnt_dst_r;
    logic      gnt_dst_vld_r;
`ifdef RR_ARB_DROP_EN
    logic      drop_r;
`endif

    port_vec_t elig_s;
    logic      found_s;
    port_idx_t win_s;
    addr_t     win_addr_s;

    // Eligibility. The status flags lag a pop or push by one cycle. The input
    // granted in this cycle and the destination granted in this cycle are
    // therefore both excluded.
    always_comb begin
        addr_t     a_s;
        port_idx_t d_s;
        logic      src_busy_s;
        logic      dst_busy_s;
        logic      valid_ok_s;
        elig_s     = 8'h00;
        a_s        = 4'h0;
        d_s        = 3'd0;
        src_busy_s = 1'b0;
        dst_busy_s = 1'b0;
        valid_ok_s = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            a_s        = bus.addr[i];
            d_s        = addr_dst(a_s);
            src_busy_s = grant_r[i];
            dst_busy_s = gnt_dst_vld_r & (gnt_dst_r == d_s);
            valid_ok_s = bus.req[i] & ~addr_invalid(a_s) & ~bus.out_full[d_s]
                         & ~src_busy_s & ~dst_busy_s;
`ifdef RR_ARB_DROP_EN
            // A discarded word pushes nothing, so only the source exclusion applies.
            elig_s[i]  = addr_invalid(a_s) ? (bus.req[i] & ~src_busy_s) : valid_ok_s;
`else
            elig_s[i]  = valid_ok_s;
`endif
        end
    end

    rr_pick u_pick (
        .elig  (elig_s),
        .ptr   (ptr_r),
        .found (found_s),
        .idx   (win_s)
    );

    assign win_addr_s = bus.addr[win_s];

    // Grant register, round-robin pointer, and destination-exclusion state.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_r       <= 8'h00;
            ptr_r         <= 3'd0;
            gnt_dst_r     <= 3'd0;
            gnt_dst_vld_r <= 1'b0;
`ifdef RR_ARB_DROP_EN
            drop_r        <= 1'b0;
`endif
        end else if (found_s) begin
            grant_r       <= idx_to_onehot(win_s);
            ptr_r         <= win_s + 3'd1;
            gnt_dst_r     <= addr_dst(win_addr_s);
`ifdef RR_ARB_DROP_EN
            gnt_dst_vld_r <= ~addr_invalid(win_addr_s);
            drop_r        <= addr_invalid(win_addr_s);
`else
            gnt_dst_vld_r <= 1'b1;
`endif
        end else begin
            grant_r       <= 8'h00;
            ptr_r         <= ptr_r;
            gnt_dst_r     <= gnt_dst_r;
            gnt_dst_vld_r <= 1'b0;
`ifdef RR_ARB_DROP_EN
            drop_r        <= 1'b0;
`endif
        end
    end

    assign bus.grant = grant_r;
    assign bus.pop   = grant_r;
`ifdef RR_ARB_DROP_EN
    assign bus.drop  = drop_r;
`else
    assign bus.drop  = 1'b0;
`endif

endmodule

// File: tb/tb_rr_grant_arb.sv
// -----------------------------------------------------------------------------
// tb_rr_grant_arb
// Directed stimulus with a queue-based scoreboard. Each stimulus cycle queues
// the grant and drop values expected after the next rising edge. A monitor
// pops one entry after every edge and compares grant, pop and drop.
// -----------------------------------------------------------------------------
module tb_rr_grant_arb;
    import router_pkg::*;

    typedef struct {
        port_vec_t g;
        logic      d;
        string     nm;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    rr_grant_arb_if bus ();

    rr_grant_arb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs at the falling edge and queue the expected result.
    task automatic cyc(input logic r, input port_vec_t rq, input logic [31:0] ad,
                       input port_vec_t of, input port_vec_t eg, input logic ed,
                       input string nm);
        @(negedge clk);
        rst          = r;
        bus.req      = rq;
        bus.addr     = ad;
        bus.out_full = of;
        exp_q.push_back('{eg, ed, nm});
    endtask

    // Monitor: compare the outputs against the scoreboard shortly after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.grant !== e.g) begin
                    errors++;
                    $display("FAIL %s grant: got %h expected %h", e.nm, bus.grant, e.g);
                end
                checks++;
                if (bus.pop !== e.g) begin
                    errors++;
                    $display("FAIL %s pop: got %h expected %h", e.nm, bus.pop, e.g);
                end
                checks++;
                if (bus.drop !== e.d) begin
                    errors++;
                    $display("FAIL %s drop: got %b expected %b", e.nm, bus.drop, e.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.req      = 8'hFF;
        bus.addr     = 32'h76543210;
        bus.out_full = 8'h00;

        // Reset held for two cycles with every input requesting.
        for (int k = 0; k < 2; k++)
            cyc(1'b1, 8'hFF, 32'h76543210, 8'h00, 8'h00, 1'b0, "reset");

        // Fairness: one grant per cycle, rotating from input 0.
        for (int k = 0; k < 10; k++)
            cyc(1'b0, 8'hFF, 32'h76543210, 8'h00, port_vec_t'(8'h01 << (k % 8)), 1'b0, "fair");

        // Idle cycle. The pointer is left at 2.
        cyc(1'b0, 8'h00, 32'h76543210, 8'h00, 8'h00, 1'b0, "idle");

        // Inputs 0 and 2 both target destination 3, starting from ptr 2.
        cyc(1'b0, 8'h05, 32'h00000303, 8'h00, 8'h04, 1'b0, "same_dst");
        cyc(1'b0, 8'h05, 32'h00000303, 8'h00, 8'h00, 1'b0, "same_dst");
        cyc(1'b0, 8'h05, 32'h00000303, 8'h00, 8'h01, 1'b0, "same_dst");
        cyc(1'b0, 8'h05, 32'h00000303, 8'h00, 8'h00, 1'b0, "same_dst");
        cyc(1'b0, 8'h05, 32'h00000303, 8'h00, 8'h04, 1'b0, "same_dst");
        cyc(1'b0, 8'h05, 32'h00000303, 8'h00, 8'h00, 1'b0, "same_dst");

        // Backpressure: output 5 is full for ten cycles, then released.
        for (int k = 0; k < 10; k++)
            cyc(1'b0, 8'h01, 32'h00000005, 8'h20, 8'h00, 1'b0, "backpressure");
        cyc(1'b0, 8'h01, 32'h00000005, 8'h00, 8'h01, 1'b0, "bp_release");
        cyc(1'b0, 8'h01, 32'h00000005, 8'h00, 8'h00, 1'b0, "bp_src_excl");
        cyc(1'b0, 8'h01, 32'h00000005, 8'h00, 8'h01, 1'b0, "bp_regrant");

        // Reset asserted while a grant is active, then restart from input 0.
        cyc(1'b1, 8'hFF, 32'h76543210, 8'h00, 8'h00, 1'b0, "rst_mid");
        cyc(1'b0, 8'hFF, 32'h76543210, 8'h00, 8'h01, 1'b0, "rst_restart");
        cyc(1'b0, 8'hFF, 32'h76543210, 8'h00, 8'h02, 1'b0, "rst_restart");

        // One-word FIFO: req stays high through the pop cycle because the
        // status flag lags by one cycle. Exactly one pop is expected.
        cyc(1'b0, 8'h08, 32'h00002000, 8'h00, 8'h08, 1'b0, "one_word");
        cyc(1'b0, 8'h08, 32'h00002000, 8'h00, 8'h00, 1'b0, "one_word_lag");
        cyc(1'b0, 8'h00, 32'h00002000, 8'h00, 8'h00, 1'b0, "one_word_empty");

`ifdef RR_ARB_DROP_EN
        // An invalid destination is granted, popped and dropped.
        cyc(1'b0, 8'h02, 32'h00000090, 8'h00, 8'h02, 1'b1, "drop_hit");
        cyc(1'b0, 8'h02, 32'h00000090, 8'h00, 8'h00, 1'b0, "drop_lag");
        // A dropped grant on input 0 (dst bits 0) must not block destination 0.
        cyc(1'b0, 8'h03, 32'h00000008, 8'h00, 8'h01, 1'b1, "drop_no_dst_excl");
        cyc(1'b0, 8'h03, 32'h00000008, 8'h00, 8'h02, 1'b0, "drop_no_dst_excl");
        cyc(1'b0, 8'h00, 32'h00000008, 8'h00, 8'h00, 1'b0, "drop_clear");
`else
        // An invalid destination is never granted.
        for (int k = 0; k < 4; k++)
            cyc(1'b0, 8'h02, 32'h00000090, 8'h00, 8'h00, 1'b0, "drop_stall");
        cyc(1'b0, 8'h00, 32'h00000090, 8'h00, 8'h00, 1'b0, "drop_clear");
`endif

        // Let the monitor drain the queue, within a bounded number of cycles.
        for (int k = 0; k < 5; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
